// File: rtl/ext_mem_axi_ram_if.sv
// AXI4 bus between the L2 cache master port and the external-memory RAM slave.
// The slave modport is used by ext_mem_axi_ram; the master modport is used by the requester side.
interface ext_mem_axi_ram_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  axi_awid;
  logic [ADDR_W-1:0]     axi_awaddr;
  logic [7:0]            axi_awlen;
  logic [2:0]            axi_awsize;
  logic [1:0]            axi_awburst;
  logic                  axi_awlock;
  logic [3:0]            axi_awcache;
  logic [2:0]            axi_awprot;
  logic [3:0]            axi_awqos;
  logic                  axi_awvalid;
  logic                  axi_awready;

  logic [DATA_W-1:0]     axi_wdata;
  logic [DATA_W/8-1:0]   axi_wstrb;
  logic                  axi_wlast;
  logic                  axi_wvalid;
  logic                  axi_wready;

  logic                  axi_bid;
  logic [1:0]            axi_bresp;
  logic                  axi_bvalid;
  logic                  axi_bready;

  logic                  axi_arid;
  logic [ADDR_W-1:0]     axi_araddr;
  logic [7:0]            axi_arlen;
  logic [2:0]            axi_arsize;
  logic [1:0]            axi_arburst;
  logic                  axi_arlock;
  logic [3:0]            axi_arcache;
  logic [2:0]            axi_arprot;
  logic [3:0]            axi_arqos;
  logic                  axi_arvalid;
  logic                  axi_arready;

  logic                  axi_rid;
  logic [DATA_W-1:0]     axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_wready,
    output axi_bid, axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
           axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_wready,
    input  axi_bid, axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst,
           axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );
endinterface

// File: rtl/ext_mem_axi_ram.sv
// AXI4 slave RAM (one burst at a time, FIXED/INCR up to 256 beats); read data one cycle after RAM issue.
// Optional EXT_MEM_AXI_RAM_ERR_EN: out-of-range bursts answer SLVERR and never touch the RAM.
module ext_mem_axi_ram #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ext_mem_axi_ram_if.slave     axi
);
  localparam int         DEPTH  = 1 << MEM_ADDR_W;
  localparam int         STRB_W = DATA_W / 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] FIXED  = 2'b00;

  typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

  state_t                state_q;
  logic                  last_rd_q;
  logic                  err_q;
  logic [1:0]            burst_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [8:0]            cnt_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic                  bid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic                  rid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_W-1:0]     rdata_q;

  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  grant_wr;
  logic                  aw_hs;
  logic                  ar_hs;
  logic                  aw_err;
  logic                  ar_err;
  logic                  w_beat;
  logic                  r_issue;
  logic [MEM_ADDR_W-1:0] addr_nxt;

  // On a tie the type not served last wins; last_rd_q resets to "read" so writes go first.
  assign grant_wr = axi.axi_awvalid & (~axi.axi_arvalid | last_rd_q);
  assign aw_hs    = (state_q == IDLE) & grant_wr;
  assign ar_hs    = (state_q == IDLE) & axi.axi_arvalid & ~grant_wr;
  assign w_beat   = (state_q == W_DATA) & axi.axi_wvalid;
  assign r_issue  = (state_q == R_DATA) & (cnt_q != 9'd0) & (~rvalid_q | axi.axi_rready);
  assign addr_nxt = (burst_q == FIXED) ? addr_q : addr_q + 1'b1;

`ifdef EXT_MEM_AXI_RAM_ERR_EN
  assign aw_err = |(axi.axi_awaddr >> (MEM_ADDR_W + 2));
  assign ar_err = |(axi.axi_araddr >> (MEM_ADDR_W + 2));
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  assign axi.axi_awready = aw_hs;
  assign axi.axi_arready = ar_hs;
  assign axi.axi_wready  = wready_q;
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bid     = bid_q;
  assign axi.axi_bresp   = bresp_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rid     = rid_q;
  assign axi.axi_rlast   = rlast_q;
  assign axi.axi_rresp   = rresp_q;
  assign axi.axi_rdata   = rdata_q;

  // Sizes, cache/prot/qos, wlast and the sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{axi.axi_awsize, axi.axi_awlock, axi.axi_awcache, axi.axi_awprot,
                       axi.axi_awqos, axi.axi_wlast, axi.axi_awaddr,
                       axi.axi_arsize, axi.axi_arlock, axi.axi_arcache, axi.axi_arprot,
                       axi.axi_arqos, axi.axi_araddr};

  always_ff @(posedge clk) begin
    if (w_beat && !err_q) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi.axi_wstrb[b]) mem[addr_q][8*b +: 8] <= axi.axi_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      err_q     <= 1'b0;
      burst_q   <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rid_q     <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aw_hs) begin
            bid_q     <= axi.axi_awid;
            addr_q    <= axi.axi_awaddr[MEM_ADDR_W+1:2];
            cnt_q     <= {1'b0, axi.axi_awlen} + 9'd1;
            burst_q   <= axi.axi_awburst;
            err_q     <= aw_err;
            wready_q  <= 1'b1;
            last_rd_q <= 1'b0;
            state_q   <= W_DATA;
          end else if (ar_hs) begin
            rid_q     <= axi.axi_arid;
            addr_q    <= axi.axi_araddr[MEM_ADDR_W+1:2];
            cnt_q     <= {1'b0, axi.axi_arlen} + 9'd1;
            burst_q   <= axi.axi_arburst;
            err_q     <= ar_err;
            last_rd_q <= 1'b1;
            state_q   <= R_DATA;
          end
        end
        W_DATA: begin
          if (axi.axi_wvalid) begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q - 9'd1;
            if (cnt_q == 9'd1) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= err_q ? SLVERR : OKAY;
              state_q  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.axi_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        R_DATA: begin
          // A new issue doubles as the pop of the beat just accepted; the final pop has no issue.
          if (r_issue) begin
            rdata_q  <= err_q ? '0 : mem[addr_q];
            rresp_q  <= err_q ? SLVERR : OKAY;
            rlast_q  <= (cnt_q == 9'd1);
            rvalid_q <= 1'b1;
            addr_q   <= addr_nxt;
            cnt_q    <= cnt_q - 9'd1;
          end else if (rvalid_q && axi.axi_rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ext_mem_axi_ram.sv
// Directed plus randomized bursts against a word-array reference model of the RAM.
module tb_ext_mem_axi_ram;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_ADDR_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ext_mem_axi_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  ext_mem_axi_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_ADDR_W(MEM_ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .axi (axi)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [int];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
`ifdef EXT_MEM_AXI_RAM_ERR_EN
    return (a >> (MEM_ADDR_W + 2)) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h0000_FFFF);
  endfunction

  function automatic logic [31:0] mrd(input int w);
    return mdl.exists(w) ? mdl[w] : 32'h0;
  endfunction

  task automatic idle_inputs();
    axi.axi_awid = 0; axi.axi_awaddr = 0; axi.axi_awlen = 0; axi.axi_awsize = 3'd2;
    axi.axi_awburst = 2'b01; axi.axi_awlock = 0; axi.axi_awcache = 0; axi.axi_awprot = 0;
    axi.axi_awqos = 0; axi.axi_awvalid = 0;
    axi.axi_wdata = 0; axi.axi_wstrb = 0; axi.axi_wlast = 0; axi.axi_wvalid = 0;
    axi.axi_bready = 0;
    axi.axi_arid = 0; axi.axi_araddr = 0; axi.axi_arlen = 0; axi.axi_arsize = 3'd2;
    axi.axi_arburst = 2'b01; axi.axi_arlock = 0; axi.axi_arcache = 0; axi.axi_arprot = 0;
    axi.axi_arqos = 0; axi.axi_arvalid = 0;
    axi.axi_rready = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, axi.axi_awready, 0);
    chk({tag, "_wready"},  axi.axi_wready, 0);
    chk({tag, "_bvalid"},  axi.axi_bvalid, 0);
    chk({tag, "_bresp"},   axi.axi_bresp, 0);
    chk({tag, "_bid"},     axi.axi_bid, 0);
    chk({tag, "_arready"}, axi.axi_arready, 0);
    chk({tag, "_rvalid"},  axi.axi_rvalid, 0);
    chk({tag, "_rdata"},   axi.axi_rdata, 0);
    chk({tag, "_rresp"},   axi.axi_rresp, 0);
    chk({tag, "_rlast"},   axi.axi_rlast, 0);
    chk({tag, "_rid"},     axi.axi_rid, 0);
  endtask

  // Burst data comes from wd/ws; the model applies byte strobes per beat.
  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic id, input bit gaps);
    bit ok = 0;
    int n = 0;
    int guard = 0;
    int w = widx(addr);
    logic [31:0] v;
    @(negedge clk);
    axi.axi_awaddr = addr; axi.axi_awlen = 8'(len); axi.axi_awburst = burst;
    axi.axi_awid = id; axi.axi_awvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (axi.axi_awready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("aw_accept", ok, 1);
    @(negedge clk);
    axi.axi_awvalid = 1'b0;
    if (!ok) return;
    #1 chk("wready_t1", axi.axi_wready, 1);
    while (n <= len && guard < 2000) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        axi.axi_wvalid = 1'b0;
      end else begin
        axi.axi_wvalid = 1'b1; axi.axi_wdata = wd[n]; axi.axi_wstrb = ws[n];
        axi.axi_wlast = (n == len);
      end
      #1;
      if (axi.axi_wvalid && axi.axi_wready) begin
        if (in_rng(addr)) begin
          v = mrd(w);
          for (int b = 0; b < 4; b++) if (ws[n][b]) v[8*b +: 8] = wd[n][8*b +: 8];
          mdl[w] = v;
        end
        if (burst != 2'b00) w = (w + 1) & 16'hFFFF;
        n++;
      end
      @(negedge clk);
      guard++;
    end
    chk("w_beats", n, len + 1);
    axi.axi_wvalid = 1'b0; axi.axi_wlast = 1'b0;
    #1;
    chk("bvalid_after_last", axi.axi_bvalid, 1);
    chk("bresp", axi.axi_bresp, in_rng(addr) ? 2'b00 : 2'b10);
    chk("bid", axi.axi_bid, id);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); #1 chk("bvalid_hold", axi.axi_bvalid, 1);
    end
    axi.axi_bready = 1'b1;
    @(negedge clk);
    axi.axi_bready = 1'b0;
    #1 chk("bvalid_drop", axi.axi_bvalid, 0);
  endtask

  // rmode 0: rready held high, 1: pattern 1,0,0,1..., 2: random. abort_at >= 0 pulses reset at that beat.
  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic id, input int rmode, input int abort_at);
    bit ok = 0;
    int n = 0;
    int guard = 0;
    int step = 0;
    bit stall = 0;
    logic [31:0] prev = 0;
    logic [31:0] expq [$];
    int w = widx(addr);
    for (int k = 0; k <= len; k++) begin
      expq.push_back(in_rng(addr) ? mrd(w) : 32'h0);
      if (burst != 2'b00) w = (w + 1) & 16'hFFFF;
    end
    @(negedge clk);
    axi.axi_araddr = addr; axi.axi_arlen = 8'(len); axi.axi_arburst = burst;
    axi.axi_arid = id; axi.axi_arvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (axi.axi_arready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("ar_accept", ok, 1);
    @(negedge clk);
    axi.axi_arvalid = 1'b0;
    if (!ok) return;
    #1 chk("rvalid_t1", axi.axi_rvalid, 0);
    @(negedge clk);
    #1 chk("rvalid_t2", axi.axi_rvalid, 1);
    while (n <= len && guard < 3000) begin
      case (rmode)
        0:       axi.axi_rready = 1'b1;
        1:       axi.axi_rready = (step % 3) == 0;
        default: axi.axi_rready = 1'($urandom_range(0, 1));
      endcase
      step++;
      #1;
      if (axi.axi_rvalid) begin
        if (stall) chk("r_stall_stable", axi.axi_rdata, prev);
        chk("rdata", axi.axi_rdata, expq[n]);
        chk("rlast", axi.axi_rlast, n == len);
        chk("rid", axi.axi_rid, id);
        chk("rresp", axi.axi_rresp, in_rng(addr) ? 2'b00 : 2'b10);
        if (n == abort_at) begin
          rst = 1'b0;
          #1;
          chk("abort_rvalid", axi.axi_rvalid, 0);
          chk("abort_rdata", axi.axi_rdata, 0);
          chk("abort_rlast", axi.axi_rlast, 0);
          axi.axi_rready = 1'b0;
          @(negedge clk);
          rst = 1'b1;
          return;
        end
        prev  = axi.axi_rdata;
        stall = !axi.axi_rready;
        if (axi.axi_rready) n++;
      end
      @(negedge clk);
      guard++;
    end
    chk("r_beats", n, len + 1);
    axi.axi_rready = 1'b0;
    #1 chk("rvalid_after_last", axi.axi_rvalid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int l;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("rst_held");
    @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_outputs("rst_rel");

    // 16-beat INCR write and readback
    for (int i = 0; i < 16; i++) begin wd[i] = i; ws[i] = 4'hF; end
    do_write(32'h100, 15, 2'b01, 1'b1, 1'b0);
    do_read(32'h100, 15, 2'b01, 1'b1, 0, -1);

    // partial-strobe overwrite
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'hF;
    do_write(32'h200, 0, 2'b01, 1'b0, 1'b0);
    wd[0] = 32'h0000_0011; ws[0] = 4'h1;
    do_write(32'h200, 0, 2'b01, 1'b0, 1'b0);
    do_read(32'h200, 0, 2'b01, 1'b0, 0, -1);

    // stalled read, rready 1,0,0,1,...
    do_read(32'h100, 3, 2'b01, 1'b0, 1, -1);

    // simultaneous AW/AR twice: write first, then read
    @(negedge clk);
    axi.axi_awvalid = 1'b1; axi.axi_awaddr = 32'h300; axi.axi_arvalid = 1'b1; axi.axi_araddr = 32'h100;
    #1;
    chk("arb1_awready", axi.axi_awready, 1);
    chk("arb1_arready", axi.axi_arready, 0);
    axi.axi_awvalid = 1'b0; axi.axi_arvalid = 1'b0;
    wd[0] = 32'h1234_5678; ws[0] = 4'hF;
    do_write(32'h300, 0, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    axi.axi_awvalid = 1'b1; axi.axi_awaddr = 32'h300; axi.axi_arvalid = 1'b1; axi.axi_araddr = 32'h300;
    #1;
    chk("arb2_awready", axi.axi_awready, 0);
    chk("arb2_arready", axi.axi_arready, 1);
    axi.axi_awvalid = 1'b0; axi.axi_arvalid = 1'b0;
    do_read(32'h300, 0, 2'b01, 1'b1, 0, -1);

    // FIXED burst keeps the last beat
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write(32'h40, 3, 2'b00, 1'b0, 1'b0);
    do_read(32'h40, 0, 2'b01, 1'b0, 0, -1);
    do_read(32'h40, 2, 2'b00, 1'b1, 2, -1);

    // 256-beat fill and readback
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h1000, 255, 2'b01, 1'b1, 1'b0);
    do_read(32'h1000, 255, 2'b01, 1'b0, 2, -1);

    // INCR wrap past the top of the RAM
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(32'h0003_FFF8, 3, 2'b01, 1'b0, 1'b0);
    do_read(32'h0003_FFF8, 3, 2'b01, 1'b1, 0, -1);

    // random bursts inside the filled window
    for (int it = 0; it < 8; it++) begin
      a = 32'h1000 + 4 * $urandom_range(0, 200);
      l = $urandom_range(0, 40);
      for (int i = 0; i <= l; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write(a, l, ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01, 1'($urandom), 1'b1);
      a = 32'h1000 + 4 * $urandom_range(0, 200);
      do_read(a, $urandom_range(0, 40), ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01,
              1'($urandom), 2, -1);
    end

    // reset during beat 5 of a 16-beat read, then a normal read
    do_read(32'h1000, 15, 2'b01, 1'b1, 0, 4);
    #1 chk_reset_outputs("mid_rst");
    do_read(32'h100, 15, 2'b01, 1'b0, 0, -1);

    // address above the RAM: aliases by default, SLVERR when range checking is built in
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + i; ws[i] = 4'hF; end
    do_write(32'h0008_0100, 3, 2'b01, 1'b1, 1'b0);
    do_read(32'h0008_0100, 3, 2'b01, 1'b1, 0, -1);
    do_read(32'h100, 3, 2'b01, 1'b0, 0, -1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
